// File: rtl/clock_pkg.sv
// Shared field constants and packed time layout for the time-of-day keeper.
// Field order in every 24-bit bundle is {hour, minute, second}.
package clock_pkg;

  localparam int FIELD_W = 8;

  localparam int SEC  = 0;
  localparam int MIN  = 1;
  localparam int HOUR = 2;

  typedef struct packed {
    logic [FIELD_W-1:0] hour;
    logic [FIELD_W-1:0] minute;
    logic [FIELD_W-1:0] second;
  } time_t;

  // 24h -> 12h display hour: 0 shows as 12, 13..23 as 1..11.
  function automatic logic [FIELD_W-1:0] fmt12(
    input logic [FIELD_W-1:0] h
  );
    if (h == '0) begin
      return FIELD_W'(12);
    end else if (h > FIELD_W'(12)) begin
      return h - FIELD_W'(12);
    end else begin
      return h;
    end
  endfunction

endpackage

// File: rtl/mod_field_counter.sv
// One modulo time field: load, +/-1 adjust and carry-driven advance.
// carry_out flags that an incoming carry wraps this field to zero.
module mod_field_counter
  import clock_pkg::*;
#(
  parameter int MOD         = 60,
  parameter int RESET_VALUE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               carry_in,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic               carry_out
);

  localparam logic [FIELD_W-1:0] MAX = FIELD_W'(MOD - 1);
  localparam logic [FIELD_W-1:0] RST = FIELD_W'(RESET_VALUE);

  logic [FIELD_W-1:0] value_q;
  logic [FIELD_W-1:0] value_d;
  logic               at_max;

  assign at_max = (value_q == MAX);

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (load_val > MAX) ? '0 : load_val;
    end else if (inc && !dec) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end else if (dec && !inc) begin
      value_d = (value_q == '0) ? MAX : value_q - 1'b1;
    end else if (carry_in) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RST;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_in & at_max;

endmodule

// File: rtl/clock_multi.sv
// Single-clock time-of-day keeper: tick advance, per-field adjust,
// parallel load, 12/24h display, one-shot alarm and day pulse.
module clock_multi
  import clock_pkg::*;
#(
  parameter int HOUR_MOD     = 24,
  parameter int MINUTE_MOD   = 60,
  parameter int SECOND_MOD   = 60,
  parameter int RESET_HOUR   = 8,
  parameter int RESET_MINUTE = 0,
  parameter int RESET_SECOND = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tick,
  input  logic [2:0]  signal_increase,
  input  logic [2:0]  signal_decrease,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        mode_12h,
  input  logic        alarm_en,
  input  logic [23:0] alarm_time,
  output logic [7:0]  cur_second,
  output logic [7:0]  cur_minute,
  output logic [7:0]  cur_hour,
  output logic        cur_pm,
  output logic        alarm_hit,
  output logic        day_pulse
);

  localparam bit IS24 = (HOUR_MOD == 24);

  time_t lt;
  time_t cur;
  time_t nxt;

  logic [2:0] inc_prev_q;
  logic [2:0] dec_prev_q;
  logic [2:0] inc_f;
  logic [2:0] dec_f;
  logic       adj_ok;
  logic       any_adj;
  logic       tick_go;
  logic       sec_co;
  logic       min_co;
  logic       hr_co;
  logic       alarm_q;
  logic       alarm_d;
  logic       day_q;
  logic       day_d;

  assign lt = time_t'(load_time);

  // Adjust edges only count when running and not overridden by load.
  assign adj_ok  = en & ~load;
  assign inc_f   = signal_increase & ~inc_prev_q & {3{adj_ok}};
  assign dec_f   = signal_decrease & ~dec_prev_q & {3{adj_ok}};
  assign any_adj = |(inc_f | dec_f);
  assign tick_go = en & tick & ~load & ~any_adj;

  mod_field_counter #(
    .MOD         (SECOND_MOD),
    .RESET_VALUE (RESET_SECOND)
  ) u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_f[SEC]),
    .dec       (dec_f[SEC]),
    .carry_in  (tick_go),
    .load      (load),
    .load_val  (lt.second),
    .value     (cur.second),
    .carry_out (sec_co)
  );

  mod_field_counter #(
    .MOD         (MINUTE_MOD),
    .RESET_VALUE (RESET_MINUTE)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_f[MIN]),
    .dec       (dec_f[MIN]),
    .carry_in  (sec_co),
    .load      (load),
    .load_val  (lt.minute),
    .value     (cur.minute),
    .carry_out (min_co)
  );

  mod_field_counter #(
    .MOD         (HOUR_MOD),
    .RESET_VALUE (RESET_HOUR)
  ) u_hour (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_f[HOUR]),
    .dec       (dec_f[HOUR]),
    .carry_in  (min_co),
    .load      (load),
    .load_val  (lt.hour),
    .value     (cur.hour),
    .carry_out (hr_co)
  );

  // Time the counters will hold after this cycle's tick.
  always_comb begin
    nxt        = cur;
    nxt.second = sec_co ? '0 : cur.second + 1'b1;
    if (min_co) begin
      nxt.minute = '0;
    end else if (sec_co) begin
      nxt.minute = cur.minute + 1'b1;
    end
    if (hr_co) begin
      nxt.hour = '0;
    end else if (min_co) begin
      nxt.hour = cur.hour + 1'b1;
    end
  end

  assign alarm_d = tick_go & alarm_en &
                   (nxt == time_t'(alarm_time));
  assign day_d   = hr_co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_prev_q <= '0;
      dec_prev_q <= '0;
      alarm_q    <= 1'b0;
      day_q      <= 1'b0;
    end else begin
      inc_prev_q <= signal_increase;
      dec_prev_q <= signal_decrease;
      alarm_q    <= alarm_d;
      day_q      <= day_d;
    end
  end

  assign cur_second = cur.second;
  assign cur_minute = cur.minute;
  assign cur_hour   = (mode_12h && IS24) ? fmt12(cur.hour)
                                         : cur.hour;
  assign cur_pm     = IS24 && (cur.hour >= 8'd12);
  assign alarm_hit  = alarm_q;
  assign day_pulse  = day_q;

endmodule

// File: tb/tb_clock_multi.sv
// Vector table, async reset sequence and random run against a
// seconds-of-day reference model for clock_multi.
module tb_clock_multi;

  typedef struct {
    bit        en;
    bit        tk;
    bit [2:0]  inc;
    bit [2:0]  dec;
    bit        ld;
    bit [23:0] lt;
    bit        m12;
    bit        aen;
    bit [23:0] at;
    bit [23:0] et;
    bit        pm;
    bit        dy;
    bit        al;
  } vec_t;

  logic        clk = 0;
  logic        rst;
  logic        en;
  logic        tick;
  logic [2:0]  signal_increase;
  logic [2:0]  signal_decrease;
  logic        load;
  logic [23:0] load_time;
  logic        mode_12h;
  logic        alarm_en;
  logic [23:0] alarm_time;
  logic [7:0]  cur_second;
  logic [7:0]  cur_minute;
  logic [7:0]  cur_hour;
  logic        cur_pm;
  logic        alarm_hit;
  logic        day_pulse;

  int total = 0;
  int bad   = 0;

  // reference model: time as seconds since midnight
  int     mt;
  bit [2:0] mpi;
  bit [2:0] mpd;
  bit     mday;
  bit     mal;

  vec_t tab[29];

  clock_multi dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .tick            (tick),
    .signal_increase (signal_increase),
    .signal_decrease (signal_decrease),
    .load            (load),
    .load_time       (load_time),
    .mode_12h        (mode_12h),
    .alarm_en        (alarm_en),
    .alarm_time      (alarm_time),
    .cur_second      (cur_second),
    .cur_minute      (cur_minute),
    .cur_hour        (cur_hour),
    .cur_pm          (cur_pm),
    .alarm_hit       (alarm_hit),
    .day_pulse       (day_pulse)
  );

  always #5 clk = ~clk;

  function automatic bit [23:0] hms(int h, int m, int s);
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  function automatic vec_t mk(
    bit en_, bit tk, bit [2:0] inc, bit [2:0] dec,
    bit ld, bit [23:0] lt, bit m12, bit aen,
    bit [23:0] at, bit [23:0] et, bit pm, bit dy, bit al
  );
    vec_t v;
    v.en = en_; v.tk = tk; v.inc = inc; v.dec = dec;
    v.ld = ld; v.lt = lt; v.m12 = m12; v.aen = aen;
    v.at = at; v.et = et; v.pm = pm; v.dy = dy; v.al = al;
    return v;
  endfunction

  function automatic int clamp(bit [7:0] f, int md);
    return (int'(f) < md) ? int'(f) : 0;
  endfunction

  task automatic model_reset();
    mt = 8 * 3600; mpi = 0; mpd = 0; mday = 0; mal = 0;
  endtask

  task automatic model_step(vec_t v);
    bit [2:0] ie;
    bit [2:0] de;
    int h, m, s;
    ie = v.inc & ~mpi;
    de = v.dec & ~mpd;
    mpi = v.inc;
    mpd = v.dec;
    mday = 0;
    mal = 0;
    h = mt / 3600; m = (mt / 60) % 60; s = mt % 60;
    if (v.ld) begin
      h = clamp(v.lt[23:16], 24);
      m = clamp(v.lt[15:8], 60);
      s = clamp(v.lt[7:0], 60);
      mt = h * 3600 + m * 60 + s;
    end else if (v.en && (ie | de) != 0) begin
      s = (s + 60 + int'(ie[0]) - int'(de[0])) % 60;
      m = (m + 60 + int'(ie[1]) - int'(de[1])) % 60;
      h = (h + 24 + int'(ie[2]) - int'(de[2])) % 24;
      mt = h * 3600 + m * 60 + s;
    end else if (v.en && v.tk) begin
      mday = (mt == 86399);
      mt = (mt + 1) % 86400;
      mal = v.aen &&
            (hms(mt / 3600, (mt / 60) % 60, mt % 60) == v.at);
    end
  endtask

  function automatic bit [26:0] model_out(bit m12);
    int h, dh;
    h = mt / 3600;
    dh = h;
    if (m12) dh = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
    return {hms(dh, (mt / 60) % 60, mt % 60),
            h >= 12, mday, mal};
  endfunction

  task automatic chk(string nm, bit [26:0] exp);
    bit [26:0] got;
    got = {cur_hour, cur_minute, cur_second,
           cur_pm, day_pulse, alarm_hit};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (h,m,s,pm,day,alarm)",
               nm, got, exp);
    end
  endtask

  task automatic drive(vec_t v);
    en = v.en; tick = v.tk;
    signal_increase = v.inc; signal_decrease = v.dec;
    load = v.ld; load_time = v.lt;
    mode_12h = v.m12; alarm_en = v.aen; alarm_time = v.at;
  endtask

  // inputs applied at negedge, outputs checked one full cycle later
  task automatic cyc(vec_t v, string nm);
    drive(v);
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    chk(nm, model_out(v.m12));
  endtask

  initial begin
    vec_t z;
    vec_t r;
    z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    drive(z);
    #3;
    chk("reset_init", {hms(8, 0, 0), 3'b000});
    @(negedge clk);
    rst = 0;
    model_reset();

    tab[0]  = mk(1,0,0,0,1,hms(23,59,59),0,0,0,hms(23,59,59),1,0,0);
    tab[1]  = mk(1,1,0,0,0,0,0,0,0,hms(0,0,0),0,1,0);
    tab[2]  = mk(1,1,0,0,0,0,0,0,0,hms(0,0,1),0,0,0);
    tab[3]  = mk(1,0,0,0,1,hms(10,0,0),0,0,0,hms(10,0,0),0,0,0);
    for (int i = 4; i < 9; i++)
      tab[i] = mk(1,0,0,3'b010,0,0,0,0,0,hms(10,59,0),0,0,0);
    tab[9]  = mk(1,0,0,0,0,0,0,0,0,hms(10,59,0),0,0,0);
    tab[10] = mk(1,0,1,1,0,0,0,0,0,hms(10,59,0),0,0,0);
    tab[11] = mk(1,0,0,0,0,0,0,0,0,hms(10,59,0),0,0,0);
    tab[12] = mk(1,1,4,0,0,0,0,0,0,hms(11,59,0),0,0,0);
    tab[13] = mk(1,1,0,0,0,0,0,0,0,hms(11,59,1),0,0,0);
    tab[14] = mk(1,0,0,0,1,hms(0,30,0),1,0,0,hms(12,30,0),0,0,0);
    tab[15] = mk(1,0,0,0,1,hms(13,5,0),1,0,0,hms(1,5,0),1,0,0);
    tab[16] = mk(1,0,0,0,1,hms(12,0,0),1,0,0,hms(12,0,0),1,0,0);
    tab[17] = mk(1,0,0,0,1,hms(6,59,59),0,1,hms(7,0,0),
                 hms(6,59,59),0,0,0);
    tab[18] = mk(1,1,0,0,0,0,0,1,hms(7,0,0),hms(7,0,0),0,0,1);
    tab[19] = mk(1,0,0,0,0,0,0,1,hms(7,0,0),hms(7,0,0),0,0,0);
    tab[20] = mk(1,0,0,0,1,hms(7,0,0),0,1,hms(7,0,0),
                 hms(7,0,0),0,0,0);
    tab[21] = mk(1,0,0,0,1,hms(30,70,59),0,0,0,hms(0,0,59),0,0,0);
    tab[22] = mk(0,1,0,0,0,0,0,0,0,hms(0,0,59),0,0,0);
    tab[23] = mk(0,0,7,0,0,0,0,0,0,hms(0,0,59),0,0,0);
    tab[24] = mk(0,1,0,7,0,0,0,0,0,hms(0,0,59),0,0,0);
    tab[25] = mk(0,0,0,0,1,hms(5,6,7),0,0,0,hms(5,6,7),0,0,0);
    tab[26] = mk(1,1,0,0,0,0,0,0,0,hms(5,6,8),0,0,0);
    tab[27] = mk(1,1,0,0,0,0,0,0,hms(5,6,9),hms(5,6,9),0,0,0);
    tab[28] = mk(1,1,0,0,0,0,0,1,hms(5,6,10),hms(5,6,10),0,0,1);

    for (int i = 0; i < 29; i++) begin
      cyc(tab[i], $sformatf("model_vec%0d", i));
      chk($sformatf("vec%0d", i),
          {tab[i].et, tab[i].pm, tab[i].dy, tab[i].al});
    end

    // async reset while a day pulse is showing
    cyc(mk(1,0,0,0,1,hms(23,59,59),0,0,0,0,0,0,0), "pre_day");
    cyc(mk(1,1,0,0,0,0,0,0,0,0,0,0,0), "day_before_rst");
    chk("day_set", {hms(0, 0, 0), 3'b010});
    drive(z);
    #2;
    rst = 1;
    #1;
    chk("async_rst", {hms(8, 0, 0), 3'b000});
    @(negedge clk);
    rst = 0;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      int nt;
      r = z;
      r.en  = ($urandom % 8) != 0;
      r.tk  = $urandom % 2;
      r.inc = ($urandom % 3 == 0) ? 3'($urandom) : 3'b0;
      r.dec = ($urandom % 3 == 0) ? 3'($urandom) : 3'b0;
      r.ld  = ($urandom % 16) == 0;
      r.lt  = 24'($urandom);
      if ($urandom % 2)
        r.lt = hms($urandom % 24, $urandom % 60, $urandom % 60);
      r.m12 = $urandom % 2;
      r.aen = ($urandom % 4) != 0;
      nt = (mt + 1) % 86400;
      r.at = ($urandom % 2) ?
             hms(nt / 3600, (nt / 60) % 60, nt % 60) :
             hms($urandom % 24, $urandom % 60, $urandom % 60);
      cyc(r, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
